// File: rtl/conv2d_stream_engine.sv
// Streaming KxK convolution: line-buffered sliding window, pipelined multiply/adder tree, bias, ReLU, saturation.
// Latency 2+clog2(K*K) cycles from the window-completing pixel; no backpressure, pixels outside RUN are dropped.
module conv2d_stream_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int FILTER_W   = 3,
    parameter int IMG_W      = 11,
    parameter int IMG_H      = 11,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  filter_load,
    input  logic                  filter_valid,
    input  logic [DATA_WIDTH-1:0] filter_in,
    input  logic                  relu_en,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [OUT_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic                  result_last
);

    localparam int K         = FILTER_W;
    localparam int KK        = K * K;
    localparam int LVL       = $clog2(KK);
    localparam int NPAD      = 1 << LVL;
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(KK) + 1;
    localparam int PIPE_LAT  = 2 + LVL;
    localparam int CW        = $clog2(KK + 1);
    localparam int IW        = $clog2(KK);
    localparam int COLW      = $clog2(IMG_W);
    localparam int ROWW      = $clog2(IMG_H);

    localparam logic [CW-1:0]   BIAS_IDX = CW'(KK);
    localparam logic [COLW-1:0] COL_MAX  = COLW'(IMG_W - 1);
    localparam logic [ROWW-1:0] ROW_MAX  = ROWW'(IMG_H - 1);
    localparam logic [COLW-1:0] COL_WIN  = COLW'(K - 1);
    localparam logic [ROWW-1:0] ROW_WIN  = ROWW'(K - 1);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                        state, state_next;
    logic [CW-1:0]                 count, count_next;
    logic                          coef_we;
    logic [CW-1:0]                 coef_idx;
    logic                          flush;

    logic signed [DATA_WIDTH-1:0]  coef [0:KK-1];
    logic signed [DATA_WIDTH-1:0]  bias;

    logic [COLW-1:0]               col;
    logic [ROWW-1:0]               row;
    logic                          accept;
    logic                          win_ok;
    logic                          frame_last;

    logic signed [DATA_WIDTH-1:0]  lbuf    [0:K-2][0:IMG_W-1];
    logic signed [DATA_WIDTH-1:0]  col_new [0:K-1];
    logic signed [DATA_WIDTH-1:0]  win      [0:K-1][0:K-1];
    logic signed [DATA_WIDTH-1:0]  win_next [0:K-1][0:K-1];
    logic signed [PW-1:0]          prod [0:NPAD-1];
    logic signed [ACC_WIDTH-1:0]   tree [0:LVL][0:NPAD-1];

    logic [PIPE_LAT-1:0]           vld_pipe;
    logic [PIPE_LAT-1:0]           last_pipe;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_rect;
    logic signed [OUT_WIDTH-1:0]   sat;

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_LOAD;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        coef_we    = 1'b0;
        coef_idx   = count;
        flush      = 1'b0;
        case (state)
            ST_LOAD: begin
                if (filter_load) begin
                    flush      = 1'b1;
                    coef_idx   = '0;
                    count_next = '0;
                    if (filter_valid) begin
                        coef_we    = 1'b1;
                        count_next = CW'(1);
                    end
                end else if (filter_valid) begin
                    coef_we    = 1'b1;
                    count_next = count + 1'b1;
                    if (count == BIAS_IDX) begin
                        state_next = ST_RUN;
                        count_next = '0;
                    end
                end
            end
            ST_RUN: begin
                if (filter_load) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    flush      = 1'b1;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    assign ready = (state == ST_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < KK; i++) coef[i] <= '0;
            bias <= '0;
        end else if (coef_we) begin
            if (coef_idx == BIAS_IDX) bias <= filter_in;
            else                      coef[coef_idx[IW-1:0]] <= filter_in;
        end
    end

    // ---------------------------------------------------------------- raster position
    // A pixel arriving together with filter_load is dropped so the counters restart cleanly.
    assign accept     = ready && data_valid && !filter_load;
    assign win_ok     = accept && (row >= ROW_WIN) && (col >= COL_WIN);
    assign frame_last = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- line buffers and window
    // Buffers are addressed by column, so each slot holds the pixel one row above the incoming one.
    always_ff @(posedge clock) begin
        if (accept) begin
            lbuf[0][col] <= data_in;
            for (int j = 1; j < K - 1; j++) lbuf[j][col] <= lbuf[j-1][col];
        end
    end

    always_comb begin
        col_new[K-1] = data_in;
        for (int j = 0; j < K - 1; j++) col_new[K-2-j] = lbuf[j][col];
    end

    always_comb begin
        win_next = win;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_next[r][c] = win[r][c+1];
                win_next[r][K-1] = col_new[r];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win[r][c] <= '0;
        end else begin
            win <= win_next;
        end
    end

    // ---------------------------------------------------------------- multiply and adder tree
    // Products come from the post-shift window so the first stage registers in the accept cycle.
    always_comb begin
        for (int i = 0; i < NPAD; i++) prod[i] = '0;
        for (int i = 0; i < KK; i++)
            prod[i] = PW'(win_next[i / K][i % K]) * PW'(coef[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int l = 0; l <= LVL; l++)
                for (int i = 0; i < NPAD; i++) tree[l][i] <= '0;
        end else begin
            for (int i = 0; i < NPAD; i++) tree[0][i] <= ACC_WIDTH'(prod[i]);
            for (int l = 0; l < LVL; l++) begin
                for (int i = 0; i < NPAD / 2; i++)
                    tree[l+1][i] <= tree[l][2*i] + tree[l][2*i+1];
                for (int i = NPAD / 2; i < NPAD; i++)
                    tree[l+1][i] <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[PIPE_LAT-2:0], win_ok};
            last_pipe <= {last_pipe[PIPE_LAT-2:0], frame_last};
        end
    end

    // ---------------------------------------------------------------- bias, ReLU, saturation
    assign acc      = tree[LVL][0] + ACC_WIDTH'(bias);
    assign acc_rect = (relu_en && acc[ACC_WIDTH-1]) ? '0 : acc;

    generate
        if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
            localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
                {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
                {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
            always_comb begin
                if (acc_rect > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
                else if (acc_rect < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
                else                         sat = acc_rect[OUT_WIDTH-1:0];
            end
        end else begin : g_nosat
            assign sat = OUT_WIDTH'(acc_rect);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset)               result <= '0;
        else if (vld_pipe[LVL])  result <= sat;
    end

    assign result_valid = vld_pipe[PIPE_LAT-1];
    assign result_last  = vld_pipe[PIPE_LAT-1] & last_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine (K=3, 5x5 image): 16-bit and 8-bit output instances share one stimulus stream.
module tb_conv2d_stream_engine;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int PL = 2 + $clog2(K * K);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        filter_load = 1'b0;
    logic        filter_valid = 1'b0;
    logic [7:0]  filter_in = '0;
    logic        relu_en = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = '0;
    logic        ready16, ready8, rv16, rv8, rl16, rl8;
    logic [15:0] res16;
    logic [7:0]  res8;

    conv2d_stream_engine #(.DATA_WIDTH(8), .FILTER_W(K), .IMG_W(W), .IMG_H(H), .OUT_WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .filter_load(filter_load), .filter_valid(filter_valid),
        .filter_in(filter_in), .relu_en(relu_en), .data_valid(data_valid), .data_in(data_in),
        .ready(ready16), .result(res16), .result_valid(rv16), .result_last(rl16));

    conv2d_stream_engine #(.DATA_WIDTH(8), .FILTER_W(K), .IMG_W(W), .IMG_H(H), .OUT_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .filter_load(filter_load), .filter_valid(filter_valid),
        .filter_in(filter_in), .relu_en(relu_en), .data_valid(data_valid), .data_in(data_in),
        .ready(ready8), .result(res8), .result_valid(rv8), .result_last(rl8));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int v16;
        int v8;
        int cyc;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_results = 0;
    bit   mon_en = 1'b0;
    int   last16 = 0;
    int   last8 = 0;

    int   coef_m[9];
    int   bias_m = 0;
    bit   relu_m = 1'b0;
    bit   m_run = 1'b0;
    int   mrow = 0;
    int   mcol = 0;
    int   img[H][W];

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: plain 2D correlation over the stored frame, valid windows only.
    task automatic model_pixel(input int p);
        int   acc;
        exp_t e;
        img[mrow][mcol] = p;
        if (mrow >= K - 1 && mcol >= K - 1) begin
            acc = bias_m;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    acc += coef_m[r*K+c] * img[mrow-K+1+r][mcol-K+1+c];
            if (relu_m && acc < 0) acc = 0;
            e.v16  = clamp(acc, -32768, 32767);
            e.v8   = clamp(acc, -128, 127);
            e.cyc  = cyc + PL;
            e.last = (mrow == H - 1) && (mcol == W - 1);
            exp_q.push_back(e);
        end
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if ((rl16 === 1'b1 && rv16 !== 1'b1) || (rv8 !== rv16) || (rl8 !== rl16)) begin
                errors++;
                $display("FAIL flags cyc=%0d valid16=%b last16=%b valid8=%b last8=%b required last only with valid, instances equal",
                         cyc, rv16, rl16, rv8, rl8);
            end
            if (rv16 === 1'b1) begin
                n_results++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result cyc=%0d got=%0d required no result_valid", cyc, $signed(res16));
                end else begin
                    mon_e = exp_q.pop_front();
                    last16 = mon_e.v16;
                    last8  = mon_e.v8;
                    if (res16 !== 16'(mon_e.v16)) begin
                        errors++;
                        $display("FAIL result16 cyc=%0d got=%0d required=%0d", cyc, $signed(res16), mon_e.v16);
                    end
                    checks++;
                    if (res8 !== 8'(mon_e.v8)) begin
                        errors++;
                        $display("FAIL result8 cyc=%0d got=%0d required=%0d", cyc, $signed(res8), mon_e.v8);
                    end
                    checks++;
                    if (cyc !== mon_e.cyc) begin
                        errors++;
                        $display("FAIL latency got_cycle=%0d required_cycle=%0d", cyc, mon_e.cyc);
                    end
                    checks++;
                    if (rl16 !== mon_e.last) begin
                        errors++;
                        $display("FAIL result_last cyc=%0d got=%b required=%b", cyc, rl16, mon_e.last);
                    end
                end
            end else begin
                checks++;
                if (res16 !== 16'(last16) || res8 !== 8'(last8)) begin
                    errors++;
                    $display("FAIL result_hold cyc=%0d got=%0d/%0d required=%0d/%0d",
                             cyc, $signed(res16), $signed(res8), last16, last8);
                end
            end
        end
    end

    task automatic set_identity();
        for (int i = 0; i < 9; i++) coef_m[i] = 0;
        coef_m[4] = 1;
        bias_m = 0;
    endtask

    task automatic set_const(input int c, input int b);
        for (int i = 0; i < 9; i++) coef_m[i] = c;
        bias_m = b;
    endtask

    task automatic load_filter(input bit pulse, input bit combined);
        int w;
        @(negedge clock);
        data_valid = 1'b0;
        relu_en = relu_m;
        if (pulse) begin
            filter_load = 1'b1;
            #1;
            exp_q.delete();
            m_run = 1'b0;
            @(negedge clock);
            filter_load = 1'b0;
            checks++;
            if (ready16 !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_filter_load got=%b required=0", ready16);
            end
        end
        for (int i = 0; i < 10; i++) begin
            w = (i < 9) ? coef_m[i] : bias_m;
            filter_in = 8'(w);
            filter_valid = 1'b1;
            filter_load = combined && (i == 0);
            @(negedge clock);
            if (i == 8) begin
                checks++;
                if (ready16 !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_before_bias got=%b required=0", ready16);
                end
            end
            if (i == 9) begin
                checks++;
                if (ready16 !== 1'b1 || ready8 !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_bias got=%b/%b required=1", ready16, ready8);
                end
            end
        end
        filter_valid = 1'b0;
        filter_load = 1'b0;
        mrow = 0;
        mcol = 0;
        m_run = 1'b1;
    endtask

    task automatic send_pixel(input int p);
        @(negedge clock);
        data_valid = 1'b1;
        data_in = 8'(p);
        if (m_run) model_pixel(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            data_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        @(negedge clock);
        data_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        repeat (PL + 2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic check_count(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s result_count got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (ready16 !== 1'b0 || ready8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b/%b required=0", ready16, ready8);
        end
        checks++;
        if (res16 !== 16'd0 || res8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_result got=%0d/%0d required=0", res16, res8);
        end
        checks++;
        if (rv16 !== 1'b0 || rl16 !== 1'b0 || rv8 !== 1'b0 || rl8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b%b%b%b required=0000", rv16, rl16, rv8, rl8);
        end
        reset = 1'b0;
        last16 = 0;
        last8 = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_identity();
        int n0;
        set_identity();
        relu_m = 1'b0;
        load_filter(1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
            n0 = n_results;
            for (int i = 0; i < 25; i++) send_pixel(i);
            drain();
            check_count("identity", n_results - n0, 9);
        end
    endtask

    task automatic test_saturation();
        set_const(1, 5);
        relu_m = 1'b0;
        load_filter(1'b1, 1'b0);
        for (int i = 0; i < 25; i++) send_pixel(127);
        for (int i = 0; i < 25; i++) send_pixel(-128);
        drain();
        set_const(127, -128);
        load_filter(1'b1, 1'b0);
        for (int i = 0; i < 25; i++) send_pixel(127);
        for (int i = 0; i < 25; i++) send_pixel(-128);
        drain();
    endtask

    task automatic test_relu();
        set_const(-1, 0);
        for (int m = 0; m < 2; m++) begin
            relu_m = (m == 1);
            load_filter(1'b1, 1'b0);
            for (int i = 0; i < 25; i++) send_pixel(1);
            for (int i = 0; i < 25; i++) send_pixel(int'($urandom_range(0, 255)) - 128);
            drain();
        end
        relu_m = 1'b0;
    endtask

    task automatic test_gaps();
        int n0;
        set_identity();
        load_filter(1'b1, 1'b0);
        n0 = n_results;
        for (int i = 0; i < 25; i++) begin
            send_pixel(i);
            idle(int'($urandom_range(1, 3)));
        end
        drain();
        check_count("gaps", n_results - n0, 9);
    endtask

    task automatic test_random();
        int n0;
        for (int i = 0; i < 9; i++) coef_m[i] = int'($urandom_range(0, 255)) - 128;
        bias_m = int'($urandom_range(0, 255)) - 128;
        relu_m = 1'($urandom_range(0, 1));
        load_filter(1'b1, 1'b0);
        n0 = n_results;
        for (int i = 0; i < 75; i++) send_pixel(int'($urandom_range(0, 255)) - 128);
        drain();
        check_count("random", n_results - n0, 27);
        relu_m = 1'b0;
    endtask

    task automatic test_reload();
        int n0;
        set_identity();
        load_filter(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) send_pixel(i);
        set_const(1, 0);
        load_filter(1'b1, 1'b0);
        n0 = n_results;
        for (int i = 0; i < 25; i++) send_pixel(int'($urandom_range(0, 255)) - 128);
        drain();
        check_count("reload", n_results - n0, 9);
    endtask

    task automatic test_reset_mid();
        int n0;
        set_identity();
        load_filter(1'b1, 1'b0);
        for (int i = 0; i < 13; i++) send_pixel(i);
        idle(2);
        reset = 1'b1;
        #1;
        exp_q.delete();
        m_run = 1'b0;
        last16 = 0;
        last8 = 0;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (ready16 !== 1'b0 || res16 !== 16'd0 || rv16 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b result=%0d valid=%b required 0/0/0", ready16, res16, rv16);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            filter_valid = 1'b1;
            filter_in = 8'($urandom_range(0, 255));
            data_valid = 1'b1;
            data_in = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 9; i++) coef_m[i] = int'($urandom_range(0, 6)) - 3;
        bias_m = 7;
        load_filter(1'b0, 1'b1);
        n0 = n_results;
        for (int i = 0; i < 25; i++) send_pixel(int'($urandom_range(0, 255)) - 128);
        drain();
        check_count("reset_mid", n_results - n0, 9);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_relu();
        test_gaps();
        test_random();
        test_reload();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
